// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: widths, ALU op codes,
// the ID/EX control bundle and the operand-forwarding select codes.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    typedef struct packed {
        logic alu_src;
        logic reg_dst;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// Operand bypass selector for one source register: picks EX/MEM, then
// MEM/WB, then the register-file value. Register 0 is never bypassed.
module fwd_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0]  idx,
    input  logic [DATA_W-1:0]  rf_data,
    input  logic               exmem_reg_write,
    input  logic [REG_AW-1:0]  exmem_rd,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_reg_write,
    input  logic [REG_AW-1:0]  memwb_rd,
    input  logic [DATA_W-1:0]  memwb_result,
    output logic [DATA_W-1:0]  value,
    output mips_pkg::fwd_sel_e sel
);
    import mips_pkg::*;

    logic idx_nonzero_s;

    assign idx_nonzero_s = (idx != {REG_AW{1'b0}});

    // Priority bypass select; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        value = rf_data;
        sel   = FWD_RF;
        if (idx_nonzero_s && exmem_reg_write && (exmem_rd == idx)) begin
            value = exmem_result;
            sel   = FWD_EXMEM;
        end else if (idx_nonzero_s && memwb_reg_write && (memwb_rd == idx)) begin
            value = memwb_result;
            sel   = FWD_MEMWB;
        end else begin
            value = rf_data;
            sel   = FWD_RF;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble
// insertion; drives ALU operands and ALU-control inputs directly.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [1:0]        Alu_op,
    output logic [5:0]        funct,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_write_reg,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              load_use_hazard
);
    import mips_pkg::*;

    logic              valid_r,   valid_s;
    ctrl_t             ctrl_r,    ctrl_s;
    logic [1:0]        alu_op_r,  alu_op_s;
    logic [5:0]        funct_r,   funct_s;
    logic [REG_AW-1:0] rs_r,      rs_s;
    logic [REG_AW-1:0] rt_r,      rt_s;
    logic [REG_AW-1:0] rd_r,      rd_s;
    logic [DATA_W-1:0] rs_data_r, rs_data_s;
    logic [DATA_W-1:0] rt_data_r, rt_data_s;
    logic [DATA_W-1:0] imm_r,     imm_s;

    logic              hazard_s;
    logic              rt_use_s;
    logic [DATA_W-1:0] fwd_rs_s;
    logic [DATA_W-1:0] fwd_rt_s;
    fwd_sel_e          sel_rs_s;
    fwd_sel_e          sel_rt_s;
    logic              unused_sel_s;

    // Stores read rt as data even when the ALU takes the immediate.
    assign rt_use_s = (rt_r == id_rt) & (~id_alu_src | id_mem_write);
    assign hazard_s = valid_r & ctrl_r.mem_read & (rt_r != {REG_AW{1'b0}}) &
                      id_valid & ((rt_r == id_rs) | rt_use_s);
    assign load_use_hazard = hazard_s;

    // Next-state selection: flush beats stall; a load-use hazard captures a bubble.
    always_comb begin
        valid_s   = valid_r;
        ctrl_s    = ctrl_r;
        alu_op_s  = alu_op_r;
        funct_s   = funct_r;
        rs_s      = rs_r;
        rt_s      = rt_r;
        rd_s      = rd_r;
        rs_data_s = rs_data_r;
        rt_data_s = rt_data_r;
        imm_s     = imm_r;
        if (flush || (!stall && hazard_s)) begin
            valid_s   = 1'b0;
            ctrl_s    = '{default: 1'b0};
            alu_op_s  = 2'b00;
            funct_s   = 6'b000000;
            rs_s      = {REG_AW{1'b0}};
            rt_s      = {REG_AW{1'b0}};
            rd_s      = {REG_AW{1'b0}};
            rs_data_s = {DATA_W{1'b0}};
            rt_data_s = {DATA_W{1'b0}};
            imm_s     = {DATA_W{1'b0}};
        end else if (stall) begin
            valid_s   = valid_r;
        end else begin
            valid_s           = id_valid;
            ctrl_s.alu_src    = id_alu_src;
            ctrl_s.reg_dst    = id_reg_dst;
            ctrl_s.reg_write  = id_reg_write  & id_valid;
            ctrl_s.mem_read   = id_mem_read   & id_valid;
            ctrl_s.mem_write  = id_mem_write  & id_valid;
            ctrl_s.mem_to_reg = id_mem_to_reg & id_valid;
            alu_op_s          = id_alu_op;
            funct_s           = id_funct;
            rs_s              = id_rs;
            rt_s              = id_rt;
            rd_s              = id_rd;
            rs_data_s         = id_rs_data;
            rt_data_s         = id_rt_data;
            imm_s             = {{(DATA_W-16){id_imm[15]}}, id_imm};
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            ctrl_r    <= '{default: 1'b0};
            alu_op_r  <= 2'b00;
            funct_r   <= 6'b000000;
            rs_r      <= {REG_AW{1'b0}};
            rt_r      <= {REG_AW{1'b0}};
            rd_r      <= {REG_AW{1'b0}};
            rs_data_r <= {DATA_W{1'b0}};
            rt_data_r <= {DATA_W{1'b0}};
            imm_r     <= {DATA_W{1'b0}};
        end else begin
            valid_r   <= valid_s;
            ctrl_r    <= ctrl_s;
            alu_op_r  <= alu_op_s;
            funct_r   <= funct_s;
            rs_r      <= rs_s;
            rt_r      <= rt_s;
            rd_r      <= rd_s;
            rs_data_r <= rs_data_s;
            rt_data_r <= rt_data_s;
            imm_r     <= imm_s;
        end
    end

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .idx             (rs_r),
        .rf_data         (rs_data_r),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .value           (fwd_rs_s),
        .sel             (sel_rs_s)
    );

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .idx             (rt_r),
        .rf_data         (rt_data_r),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .value           (fwd_rt_s),
        .sel             (sel_rt_s)
    );

    // Select codes are observable in waveforms but not needed downstream.
    assign unused_sel_s = ^{sel_rs_s, sel_rt_s};

    assign a             = fwd_rs_s;
    assign b             = ctrl_r.alu_src ? imm_r : fwd_rt_s;
    assign ex_store_data = fwd_rt_s;
    assign Alu_op        = alu_op_r;
    assign funct         = funct_r;
    assign ex_valid      = valid_r;
    assign ex_reg_write  = ctrl_r.reg_write;
    assign ex_mem_read   = ctrl_r.mem_read;
    assign ex_mem_write  = ctrl_r.mem_write;
    assign ex_mem_to_reg = ctrl_r.mem_to_reg;
    assign ex_write_reg  = ctrl_r.reg_write ? (ctrl_r.reg_dst ? rd_r : rt_r)
                                            : {REG_AW{1'b0}};

endmodule
